// File: rtl/stage0_stop_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stage0_stop_ctrl
// Description : Freeze sequencer for the Stage0 one-shot bank: delayed,
//               minimum-length trig_stop window, readout release, guard gap.
// Revision    : 1.0 - initial release
// ============================================================================
module stage0_stop_ctrl #(
    parameter int DLY_W  = 4,
    parameter int HOLD_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stop_req,
    input  logic [DLY_W-1:0]  stop_dly,
    input  logic [HOLD_W-1:0] hold_len,
    input  logic              rel_req,
    input  logic              force_stop,
    output logic              trig_stop,
    output logic              stop_busy,
    output logic              stop_ack,
    output logic [CNT_W-1:0]  stop_cnt
);

    localparam int C_MW = (DLY_W > HOLD_W) ? DLY_W : HOLD_W;
    localparam int C_TW = (C_MW > 2) ? C_MW : 2;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DELAY    = 3'd1,
        S_HOLD     = 3'd2,
        S_WAIT_REL = 3'd3,
        S_GUARD    = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [C_TW-1:0]     r_cnt;
    logic [C_TW-1:0]     w_cnt_nxt;
    logic [HOLD_W-1:0]   r_hold;
    logic [HOLD_W-1:0]   w_hold_nxt;
    logic                r_pend;
    logic                w_pend_nxt;
    logic                r_trig;
    logic                r_busy;
    logic                r_ack;
    logic [CNT_W-1:0]    r_stop_cnt;

    logic                w_cnt_last;
    logic [C_TW-1:0]     w_hold_in_ld;
    logic [C_TW-1:0]     w_hold_q_ld;
    state_t              w_start_state;
    logic [C_TW-1:0]     w_start_cnt;
    logic                w_ack;

    assign w_cnt_last   = (r_cnt == C_TW'(1));
    // Hold length of zero behaves as one cycle.
    assign w_hold_in_ld = (hold_len == '0) ? C_TW'(1) : C_TW'(hold_len);
    assign w_hold_q_ld  = (r_hold == '0) ? C_TW'(1) : C_TW'(r_hold);

    // Episode start from the live settings; a zero delay goes straight to HOLD.
    assign w_start_state = (stop_dly == '0) ? S_HOLD : S_DELAY;
    assign w_start_cnt   = (stop_dly == '0) ? w_hold_in_ld : C_TW'(stop_dly);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hold_nxt  = r_hold;
        w_pend_nxt  = r_pend;
        case (r_state)
            S_IDLE: begin
                if (stop_req) begin
                    w_state_nxt = w_start_state;
                    w_cnt_nxt   = w_start_cnt;
                    w_hold_nxt  = hold_len;
                end
            end
            S_DELAY: begin
                if (w_cnt_last) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = w_hold_q_ld;
                end else begin
                    w_cnt_nxt = r_cnt - C_TW'(1);
                end
            end
            S_HOLD: begin
                if (w_cnt_last) begin
                    w_state_nxt = rel_req ? S_GUARD : S_WAIT_REL;
                    w_cnt_nxt   = C_TW'(2);
                end else begin
                    w_cnt_nxt = r_cnt - C_TW'(1);
                end
            end
            S_WAIT_REL: begin
                if (rel_req) begin
                    w_state_nxt = S_GUARD;
                    w_cnt_nxt   = C_TW'(2);
                end
            end
            S_GUARD: begin
                if (w_cnt_last) begin
                    w_pend_nxt = 1'b0;
                    if (r_pend || stop_req) begin
                        w_state_nxt = w_start_state;
                        w_cnt_nxt   = w_start_cnt;
                        w_hold_nxt  = hold_len;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - C_TW'(1);
                    if (stop_req) begin
                        w_pend_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_ack = (w_state_nxt == S_HOLD) && (r_state != S_HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_hold     <= '0;
            r_pend     <= 1'b0;
            r_trig     <= 1'b0;
            r_busy     <= 1'b0;
            r_ack      <= 1'b0;
            r_stop_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hold  <= w_hold_nxt;
            r_pend  <= w_pend_nxt;
            r_trig  <= (w_state_nxt == S_HOLD) || (w_state_nxt == S_WAIT_REL) || force_stop;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_ack   <= w_ack;
            if (w_ack && (r_stop_cnt != {CNT_W{1'b1}})) begin
                r_stop_cnt <= r_stop_cnt + CNT_W'(1);
            end
        end
    end

    assign trig_stop = r_trig;
    assign stop_busy = r_busy;
    assign stop_ack  = r_ack;
    assign stop_cnt  = r_stop_cnt;

endmodule
`default_nettype wire
